// File: rtl/display_pkg.sv
// Shared display-pipeline definitions.
// - scan_state_e : scanout control states (idle, fill, run, flush).
// - SYNC_ACTIVE_* : sync polarity constants, shared with the timing generator.
package display_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StRun,
      StFlush
   } scan_state_e;

   localparam logic SYNC_ACTIVE_LOW  = 1'b0;
   localparam logic SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   push_i, wdata_i   : write request and data (ignored while full)
//   pop_i, rdata_o    : read request (ignored while empty); rdata_o shows the head entry
//   clear_i           : empties the FIFO on the next edge, overrides push/pop
//   full_o, empty_o   : status
//   level_o           : occupancy, updated one cycle after push/pop
module sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4,
   localparam int unsigned AW = $clog2(Depth),
   localparam int unsigned LW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clear_i,
   input  logic [Width-1:0] wdata_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (level_q == LW'(Depth));
   assign empty_o = (level_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage needs no reset; pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/display_scanout_fifo.sv
// Pixel-clock scanout buffer between the framebuffer fetch engine and the display.
// Ports:
//   clk, rst_n                 : pixel clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_sof : fetch stream; s_sof marks pixel 0 of a frame
//   hsync_i, vsync_i, de_i     : timing generator inputs
//   hsync_o, vsync_o, de_o     : timing inputs delayed one cycle
//   rgb_o                      : pixel aligned with de_o
//   frame_req                  : pulse per VSYNC active edge (fetch kick)
//   underflow                  : pulse on empty pop or frame misalignment
//   err_sticky, clr_err        : sticky error flag and its clear (set wins)
//   fifo_level                 : FIFO occupancy
module display_scanout_fifo
   import display_pkg::*;
#(
   parameter int unsigned        DATA_W      = 24,
   parameter int unsigned        DEPTH       = 64,
   parameter int unsigned        PRIME_LEVEL = 32,
   parameter logic [DATA_W-1:0]  FILL_COLOR  = '0,
   parameter logic               HSYNC_POL   = SYNC_ACTIVE_LOW,
   parameter logic               VSYNC_POL   = SYNC_ACTIVE_LOW,
   localparam int unsigned       LW          = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_sof,
   input  logic              hsync_i,
   input  logic              vsync_i,
   input  logic              de_i,
   output logic              hsync_o,
   output logic              vsync_o,
   output logic              de_o,
   output logic [DATA_W-1:0] rgb_o,
   output logic              frame_req,
   output logic              underflow,
   output logic              err_sticky,
   input  logic              clr_err,
   output logic [LW-1:0]     fifo_level
);

   scan_state_e       state_q, state_d;
   logic              first_px_q, first_px_d;
   logic              hsync_q, vsync_q, de_q;
   logic [DATA_W-1:0] rgb_q, rgb_d;
   logic              frame_req_q, underflow_q, err_q;

   logic              push, pop, clear, full, empty;
   logic [DATA_W:0]   fifo_rdata;
   logic              pop_sof;
   logic              vs_edge;
   logic              run_err;

   sync_fifo #(
      .Width (DATA_W + 1),
      .Depth (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .clear_i (clear),
      .wdata_i ({s_sof, s_data}),
      .rdata_o (fifo_rdata),
      .full_o  (full),
      .empty_o (empty),
      .level_o (fifo_level)
   );

   assign pop_sof = fifo_rdata[DATA_W];
   // vsync_q doubles as the previous-cycle VSYNC sample.
   assign vs_edge = (vsync_i == VSYNC_POL) && (vsync_q != VSYNC_POL);
   // Pixel 0 of a frame must carry sof, every other pixel must not.
   assign run_err = (state_q == StRun) && de_i && (empty || (pop_sof != first_px_q));

   always_comb begin
      state_d    = state_q;
      first_px_d = first_px_q;
      s_ready    = 1'b1;
      push       = 1'b0;
      pop        = 1'b0;
      clear      = 1'b0;
      case (state_q)
         StIdle: begin
            // Drop beats until a frame start arrives.
            push = s_valid && s_sof;
            if (push) state_d = StFill;
         end
         StFill: begin
            s_ready = !full;
            push    = s_valid && !full;
            if (vs_edge && (fifo_level >= LW'(PRIME_LEVEL))) begin
               state_d    = StRun;
               first_px_d = 1'b1;
            end
         end
         StRun: begin
            s_ready = !full;
            push    = s_valid && !full;
            pop     = de_i && !empty;
            if (pop)     first_px_d = 1'b0;
            if (vs_edge) first_px_d = 1'b1;
            if (run_err) begin
               state_d = StFlush;
               clear   = 1'b1;
            end
         end
         StFlush: begin
            if (vs_edge) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      rgb_d = de_i ? FILL_COLOR : '0;
      if ((state_q == StRun) && de_i && !run_err) rgb_d = fifo_rdata[DATA_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         first_px_q  <= 1'b0;
         hsync_q     <= ~HSYNC_POL;
         vsync_q     <= ~VSYNC_POL;
         de_q        <= 1'b0;
         rgb_q       <= '0;
         frame_req_q <= 1'b0;
         underflow_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         first_px_q  <= first_px_d;
         hsync_q     <= hsync_i;
         vsync_q     <= vsync_i;
         de_q        <= de_i;
         rgb_q       <= rgb_d;
         frame_req_q <= vs_edge;
         underflow_q <= run_err;
         // Set on the error and held through the visible pulse cycle, so a clear
         // coinciding with the underflow pulse never wins.
         err_q       <= run_err || underflow_q || (err_q && !clr_err);
      end
   end

   assign hsync_o    = hsync_q;
   assign vsync_o    = vsync_q;
   assign de_o       = de_q;
   assign rgb_o      = rgb_q;
   assign frame_req  = frame_req_q;
   assign underflow  = underflow_q;
   assign err_sticky = err_q;

endmodule

// File: tb/tb_display_scanout_fifo.sv
// Bench for display_scanout_fifo: random fetch traffic against a queue-based reference.
module tb_display_scanout_fifo;

   localparam int unsigned DEPTH    = 64;
   localparam int unsigned PRIME    = 32;
   localparam logic [23:0] FILL     = 24'h5A5A5A;
   localparam logic        HPOL     = 1'b1;
   localparam logic        VPOL     = 1'b0;
   localparam int          H_ACT    = 8;
   localparam int          V_ACT    = 4;
   localparam int          H_TOTAL  = 12;
   localparam int          V_TOTAL  = 7;
   localparam int          FRAME_PX = H_ACT * V_ACT;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid, s_ready, s_sof;
   logic [23:0] s_data;
   logic        hsync_i, vsync_i, de_i;
   logic        hsync_o, vsync_o, de_o;
   logic [23:0] rgb_o;
   logic        frame_req, underflow, err_sticky, clr_err;
   logic [6:0]  fifo_level;

   always #5 clk = ~clk;

   display_scanout_fifo #(
      .DATA_W      (24),
      .DEPTH       (DEPTH),
      .PRIME_LEVEL (PRIME),
      .FILL_COLOR  (FILL),
      .HSYNC_POL   (HPOL),
      .VSYNC_POL   (VPOL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_sof      (s_sof),
      .hsync_i    (hsync_i),
      .vsync_i    (vsync_i),
      .de_i       (de_i),
      .hsync_o    (hsync_o),
      .vsync_o    (vsync_o),
      .de_o       (de_o),
      .rgb_o      (rgb_o),
      .frame_req  (frame_req),
      .underflow  (underflow),
      .err_sticky (err_sticky),
      .clr_err    (clr_err),
      .fifo_level (fifo_level)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model
   localparam int M_IDLE = 0, M_FILL = 1, M_RUN = 2, M_FLUSH = 3;
   logic [24:0] mq[$];
   int          m_mode = M_IDLE;
   bit          m_first = 1'b0;
   logic        m_vprev = ~VPOL;
   logic        e_hs, e_vs, e_de, e_freq, e_uf, e_err;
   logic [23:0] e_rgb;
   int          e_level;

   // Stimulus / monitor state
   bit          src_on, src_always, src_inject, last_acc, want_first, chk_err_on_uf;
   int          src_budget, src_px, clr_mode, rst_line;
   int          freq_cnt, uf_cnt, px_cnt, fill_cnt, first_seen;
   logic [23:0] src_data, beat0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_ready();
      if (m_mode == M_FILL || m_mode == M_RUN) return mq.size() < DEPTH;
      return 1'b1;
   endfunction

   function automatic void model_step();
      bit          vs, uf, push;
      int          nxt, sz0;
      logic [24:0] e;
      if (!rst_n) begin
         mq.delete();
         m_mode = M_IDLE; m_first = 1'b0; m_vprev = ~VPOL;
         e_hs = ~HPOL; e_vs = ~VPOL; e_de = 1'b0; e_rgb = '0;
         e_freq = 1'b0; e_uf = 1'b0; e_err = 1'b0; e_level = 0;
         return;
      end
      vs = (vsync_i == VPOL) && (m_vprev != VPOL);
      m_vprev = vsync_i;
      sz0 = mq.size();
      nxt = m_mode;
      uf = 1'b0;
      e_rgb = de_i ? FILL : 24'h0;
      push = s_valid && m_ready() && (m_mode != M_FLUSH) && (m_mode != M_IDLE || s_sof);
      if (m_mode == M_RUN && de_i) begin
         if (mq.size() == 0) uf = 1'b1;
         else begin
            e = mq.pop_front();
            if (e[24] != m_first) uf = 1'b1;
            else e_rgb = e[23:0];
            m_first = 1'b0;
         end
      end
      if (m_mode == M_RUN && vs) m_first = 1'b1;
      if (push) mq.push_back({s_sof, s_data});
      case (m_mode)
         M_IDLE:  if (push) nxt = M_FILL;
         M_FILL:  if (vs && sz0 >= PRIME) begin nxt = M_RUN; m_first = 1'b1; end
         M_RUN:   if (uf) begin nxt = M_FLUSH; mq.delete(); end
         default: if (vs) nxt = M_IDLE;
      endcase
      e_err   = uf || e_uf || (e_err && !clr_err);
      e_uf    = uf;
      e_freq  = vs;
      e_hs    = hsync_i;
      e_vs    = vsync_i;
      e_de    = de_i;
      e_level = mq.size();
      m_mode  = nxt;
   endfunction

   task automatic drive_src();
      if (last_acc) begin
         if (src_inject && src_px == 5) src_inject = 1'b0;
         src_px   = (src_px + 1) % FRAME_PX;
         src_data = 24'($urandom);
         if (src_budget > 0) src_budget--;
      end
      s_valid = src_on && (src_budget != 0) && (src_always || $urandom_range(3) != 0);
      s_data  = src_data;
      s_sof   = (src_px == 0) || (src_inject && src_px == 5);
      case (clr_mode)
         1:       clr_err = ($urandom_range(15) == 0);
         2:       clr_err = 1'b1;
         default: clr_err = 1'b0;
      endcase
   endtask

   task automatic tick();
      #1;
      if (rst_n) chk("s_ready", s_ready, m_ready());
      last_acc = rst_n && s_valid && m_ready();
      model_step();
      @(posedge clk);
      #1;
      chk("hsync_o", hsync_o, e_hs);
      chk("vsync_o", vsync_o, e_vs);
      chk("de_o", de_o, e_de);
      chk("rgb_o", rgb_o, e_rgb);
      chk("frame_req", frame_req, e_freq);
      chk("underflow", underflow, e_uf);
      chk("err_sticky", err_sticky, e_err);
      chk("fifo_level", fifo_level, e_level);
      if (want_first && de_o) begin
         chk("first_pixel", rgb_o, beat0);
         want_first = 1'b0;
         first_seen++;
      end
      if (underflow && chk_err_on_uf) chk("err_set_over_clr", err_sticky, 1);
      if (frame_req) freq_cnt++;
      if (underflow) uf_cnt++;
      if (de_o && rgb_o !== FILL) px_cnt++;
      if (de_o && rgb_o === FILL) fill_cnt++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         vsync_i = ~VPOL;
         hsync_i = ~HPOL;
         de_i    = 1'b0;
         drive_src();
         tick();
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      src_on = 1'b0; src_px = 0; src_inject = 1'b0; last_acc = 1'b0;
      idle(2);
      rst_n = 1'b1;
      src_data = 24'($urandom);
   endtask

   task automatic run_frame();
      for (int ln = 0; ln < V_TOTAL; ln++) begin
         for (int px = 0; px < H_TOTAL; px++) begin
            vsync_i = (ln == 0) ? VPOL : ~VPOL;
            hsync_i = (px >= 9 && px <= 10) ? HPOL : ~HPOL;
            de_i    = (ln >= 2) && (ln < 2 + V_ACT) && (px < H_ACT);
            rst_n   = !((ln == rst_line) && (px == 4));
            drive_src();
            tick();
            if (!rst_n) begin
               chk("midreset_level", fifo_level, 0);
               chk("midreset_de", de_o, 0);
               chk("midreset_rgb", rgb_o, 0);
               chk("midreset_err", err_sticky, 0);
               src_px = 0; src_inject = 1'b0; src_data = 24'($urandom);
            end
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; clr_err = 1'b0;
      hsync_i = ~HPOL; vsync_i = ~VPOL; de_i = 1'b0;
      src_on = 1'b0; src_always = 1'b0; src_inject = 1'b0; last_acc = 1'b0;
      want_first = 1'b0; chk_err_on_uf = 1'b0;
      src_budget = -1; src_px = 0; clr_mode = 0; rst_line = -1;
      freq_cnt = 0; uf_cnt = 0; px_cnt = 0; fill_cnt = 0; first_seen = 0;
      src_data = '0; beat0 = '0;

      // Reset, prefill 64 beats before any VSYNC edge, then three frames.
      do_reset();
      beat0 = src_data;
      src_always = 1'b1;
      src_on = 1'b1;
      idle(70);
      chk("prefill_full", fifo_level, 64);
      src_always = 1'b0;
      want_first = 1'b1;
      freq_cnt = 0;
      for (int f = 0; f < 3; f++) run_frame();
      chk("first_pixel_seen", first_seen, 1);
      chk("frame_req_count", freq_cnt, 3);
      chk("no_error_stream", err_sticky, 0);

      // Starve the FIFO until it underflows on DE, then recover.
      src_on = 1'b0;
      uf_cnt = 0;
      for (int f = 0; f < 5 && uf_cnt == 0; f++) run_frame();
      chk("stall_uf_count", uf_cnt, 1);
      chk("stall_err_sticky", err_sticky, 1);
      src_on = 1'b1;
      for (int f = 0; f < 3; f++) run_frame();
      px_cnt = 0;
      run_frame();
      chk("stall_recovered_px", px_cnt, FRAME_PX);

      // Clear the error, then plant a stray sof on pixel 5.
      clr_mode = 2;
      idle(1);
      clr_mode = 0;
      chk("err_cleared", err_sticky, 0);
      src_inject = 1'b1;
      uf_cnt = 0;
      for (int f = 0; f < 4; f++) run_frame();
      chk("inject_uf_count", uf_cnt, 1);
      clr_mode = 1;
      for (int f = 0; f < 4; f++) run_frame();
      clr_mode = 0;

      // One beat short of the prime level at VSYNC: stay in fill.
      do_reset();
      src_always = 1'b1;
      src_budget = PRIME - 1;
      src_on = 1'b1;
      idle(40);
      chk("prime_minus1_level", fifo_level, PRIME - 1);
      fill_cnt = 0;
      run_frame();
      chk("unprimed_fill_px", fill_cnt, FRAME_PX);
      src_budget = -1;
      src_always = 1'b0;
      run_frame();
      px_cnt = 0;
      run_frame();
      chk("primed_run_px", px_cnt, FRAME_PX);

      // Reset in the middle of an active line, then restart.
      rst_line = 3;
      run_frame();
      rst_line = -1;
      for (int f = 0; f < 3; f++) run_frame();

      // Clear held high while an underflow fires: set must win.
      clr_mode = 2;
      chk_err_on_uf = 1'b1;
      src_on = 1'b0;
      uf_cnt = 0;
      for (int f = 0; f < 5 && uf_cnt == 0; f++) run_frame();
      chk("clr_uf_count", uf_cnt, 1);
      chk_err_on_uf = 1'b0;
      clr_mode = 0;
      idle(2);
      chk("err_cleared_after", err_sticky, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
